// File: rtl/pl_mem_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 size codes,
// the ResultSrc load encoding, the FSM state type and the lane helpers.
package pl_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RES_MEM = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    // Byte enables for an access of the given size at the given word offset.
    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate right-justified store data across every lane it may land in.
    function automatic logic [31:0] store_replicate(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] rep;
        case (f3[1:0])
            2'b00:   rep = {4{wd[7:0]}};
            2'b01:   rep = {2{wd[15:0]}};
            default: rep = wd;
        endcase
        return rep;
    endfunction

    // Natural-alignment violation: halves need an even address, words need offset 0.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/pl_mem_lsu_load_align.sv
// Load extraction: picks the byte or half addressed by the offset out of the
// read word and sign- or zero-extends it according to funct3.
module pl_load_align
    import pl_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection followed by size/sign handling.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        data   = word;
        case (off)
            2'b00:   byte_s = word[7:0];
            2'b01:   byte_s = word[15:8];
            2'b10:   byte_s = word[23:16];
            2'b11:   byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase
        if (off[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
        case (funct3)
            F3_B:    data = {{24{byte_s[7]}}, byte_s};
            F3_H:    data = {{16{half_s[15]}}, half_s};
            F3_BU:   data = {24'h000000, byte_s};
            F3_HU:   data = {16'h0000, half_s};
            F3_W:    data = word;
            default: data = word;
        endcase
    end

endmodule

// File: rtl/pl_mem_lsu.sv
// Memory-stage load/store unit. Converts the M-stage access into a req/ack bus
// transaction and returns aligned, extended load data. StallM holds the
// pipeline while a transaction is being issued or is outstanding.
// Optional feature macro: PL_LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// halves/words raise MisalignM and never reach the bus; otherwise they are
// served from the containing word.
module pl_mem_lsu
    import pl_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    input  logic [1:0]        ResultSrcM,
    input  logic              MemWriteM,
    input  logic [2:0]        funct3M,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_be,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack,
    output logic [31:0]       ReadDataM,
    output logic              StallM
`ifdef PL_LSU_MISALIGN_TRAP_EN
    ,
    output logic              MisalignM
`endif
);

    lsu_state_e  state_r;
    logic [1:0]  off_r;
    logic [2:0]  f3_r;
    logic        access_s;
    logic        mis_s;
    logic        go_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] align_s;

    // Decode the M-stage instruction into an access request and its lane shaping.
    always_comb begin
        access_s = MemWriteM | (ResultSrcM == RES_MEM);
        be_s     = byte_enable(funct3M, ALUResultM[1:0]);
        wdata_s  = store_replicate(funct3M, WriteDataM);
`ifdef PL_LSU_MISALIGN_TRAP_EN
        mis_s    = access_s & is_misaligned(funct3M, ALUResultM[1:0]);
`else
        mis_s    = 1'b0;
`endif
        go_s     = access_s & ~mis_s;
    end

    // Hold the pipeline while an access is being launched or awaits its ack.
    always_comb begin
        StallM = 1'b0;
        if (state_r == ST_WAIT) begin
            StallM = 1'b1;
        end else if (state_r == ST_IDLE) begin
            StallM = go_s;
        end else begin
            StallM = 1'b0;
        end
    end

`ifdef PL_LSU_MISALIGN_TRAP_EN
    // Misalignment flag is reported in the same cycle the access is presented.
    always_comb begin
        MisalignM = mis_s;
    end
`endif

    pl_load_align u_align (
        .word   (bus_rdata),
        .off    (off_r),
        .funct3 (f3_r),
        .data   (align_s)
    );

    // Transaction FSM with registered bus outputs and load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= {ADDR_W{1'b0}};
            bus_wdata <= 32'h0000_0000;
            bus_be    <= 4'b0000;
            off_r     <= 2'b00;
            f3_r      <= 3'b000;
            ReadDataM <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (go_s) begin
                        state_r   <= ST_WAIT;
                        bus_req   <= 1'b1;
                        bus_we    <= MemWriteM;
                        bus_addr  <= {ALUResultM[ADDR_W-1:2], 2'b00};
                        bus_wdata <= wdata_s;
                        bus_be    <= be_s;
                        off_r     <= ALUResultM[1:0];
                        f3_r      <= funct3M;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (bus_ack) begin
                        state_r <= ST_DONE;
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            ReadDataM <= align_s;
                        end else begin
                            ReadDataM <= ReadDataM;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pl_mem_lsu.sv
// Self-checking bench for pl_mem_lsu: directed cases followed by randomized
// back-to-back accesses, compared against an arithmetic reference model.
module tb_pl_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ALUResultM = 32'h0;
    logic [31:0] WriteDataM = 32'h0;
    logic [1:0]  ResultSrcM = 2'b00;
    logic        MemWriteM = 1'b0;
    logic [2:0]  funct3M = 3'b000;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_ack = 1'b0;
    logic [31:0] ReadDataM;
    logic        StallM;
`ifdef PL_LSU_MISALIGN_TRAP_EN
    logic        MisalignM;
`endif

    int checks = 0;
    int passes = 0;
    logic [31:0] last_rd = 32'h0;

    pl_mem_lsu #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ResultSrcM (ResultSrcM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM)
`ifdef PL_LSU_MISALIGN_TRAP_EN
        ,
        .MisalignM  (MisalignM)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic logic [31:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
        if (sz == 1) return 32'(1 << (a % 4));
        if (sz == 2) return 32'(3 << (2 * ((a / 2) % 2)));
        return 32'd15;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 % 4 == 0) return (wd & 32'hFF) * 32'h0101_0101;
        if (f3 % 4 == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
            return v;
        end
        if (f3 == 3'd1 || f3 == 3'd5) begin
            v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
            return v;
        end
        return rd;
    endfunction

    function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
        if (f3 % 4 == 1) return (a % 2) != 0;
        if (f3 % 4 == 0) return 1'b0;
        return (a % 4) != 0;
    endfunction

    task automatic clear_inputs();
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
    endtask

    // One M-stage instruction, with the bench acting as the bus slave.
    task automatic run_op(input bit st, input bit ld, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int waits, input logic [31:0] rd);
        int  stalls;
        int  reqs;
        int  cyc;
        bit  acc;
        bit  mis;
        acc = st | ld;
        @(negedge clk);
        MemWriteM  = st;
        ResultSrcM = ld ? 2'b01 : ((($urandom % 2) == 0) ? 2'b00 : 2'b10);
        funct3M    = f3;
        ALUResultM = a;
        WriteDataM = wd;
        #1;
        mis = 1'b0;
`ifdef PL_LSU_MISALIGN_TRAP_EN
        mis = acc && m_mis(f3, a);
        check("misalign_flag", {31'd0, MisalignM}, {31'd0, mis});
`endif
        if (!acc || mis) begin
            check("idle_stall", {31'd0, StallM}, 32'd0);
            @(negedge clk);
            #1;
            check("idle_req", {31'd0, bus_req}, 32'd0);
            clear_inputs();
            return;
        end
        stalls = 0;
        reqs   = 0;
        cyc    = 0;
        while (StallM === 1'b1 && cyc < 50) begin
            stalls++;
            if (bus_req === 1'b1) begin
                reqs++;
                check("bus_we", {31'd0, bus_we}, {31'd0, st});
                check("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
                check("bus_be", {28'd0, bus_be}, m_be(f3, a));
                if (st) check("bus_wdata", bus_wdata, m_wd(f3, wd));
                if (reqs == waits + 1) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rd;
                end
            end
            @(negedge clk);
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
            #1;
            cyc++;
        end
        check("stall_cycles", stalls, 2 + waits);
        check("done_req", {31'd0, bus_req}, 32'd0);
        if (!st) last_rd = m_rd(f3, a, rd);
        check("read_data", ReadDataM, last_rd);
    endtask

    logic [2:0] ld_codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        int kind;
        logic [2:0] f3;
        // reset state
        #12;
        check("rst_req", {31'd0, bus_req}, 32'd0);
        check("rst_we", {31'd0, bus_we}, 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_be", {28'd0, bus_be}, 32'd0);
        check("rst_rdata", ReadDataM, 32'd0);
        check("rst_stall", {31'd0, StallM}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // non-memory instructions
        run_op(1'b0, 1'b0, 3'd2, 32'h0000_0100, 32'h1, 0, 32'h0);
        run_op(1'b0, 1'b0, 3'd0, 32'h0000_0203, 32'h2, 0, 32'h0);

        // directed cases
        run_op(1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0);
        run_op(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0000_00AB, 0, 32'h0);
        run_op(1'b0, 1'b1, 3'd0, 32'h0000_0102, 32'h0, 0, 32'h12F0_5634);
        check("lb_const", ReadDataM, 32'hFFFF_FFF0);
        run_op(1'b0, 1'b1, 3'd4, 32'h0000_0102, 32'h0, 1, 32'h12F0_5634);
        check("lbu_const", ReadDataM, 32'h0000_00F0);
        run_op(1'b0, 1'b1, 3'd1, 32'h0000_0102, 32'h0, 3, 32'h8001_0000);
        check("lh_const", ReadDataM, 32'hFFFF_8001);
        run_op(1'b1, 1'b0, 3'd1, 32'h0000_0042, 32'h1234_5678, 2, 32'h0);
        check("store_keeps_rd", ReadDataM, 32'hFFFF_8001);
        run_op(1'b0, 1'b1, 3'd2, 32'h0000_0102, 32'h0, 0, 32'hA5A5_0F0F);

        // reset in the middle of a WAIT
        @(negedge clk);
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b01;
        funct3M    = 3'd2;
        ALUResultM = 32'h0000_0200;
        @(negedge clk);
        #1;
        check("pre_rst_req", {31'd0, bus_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, bus_req}, 32'd0);
        check("mid_rst_rdata", ReadDataM, 32'd0);
        clear_inputs();
        #1;
        check("mid_rst_stall", {31'd0, StallM}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        check("late_ack_rdata", ReadDataM, 32'd0);
        check("late_ack_req", {31'd0, bus_req}, 32'd0);
        check("late_ack_stall", {31'd0, StallM}, 32'd0);
        last_rd = 32'd0;

        // randomized back-to-back traffic
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            if (kind == 1) f3 = ld_codes[$urandom_range(0, 4)];
            else           f3 = 3'($urandom_range(0, 2));
            run_op(kind == 0 || kind == 2, kind == 1 || kind == 2, f3,
                   $urandom, $urandom, $urandom_range(0, 3), $urandom);
        end

        @(negedge clk);
        clear_inputs();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pl_mem_lsu.md
# pl_mem_lsu

Memory-stage load/store unit: the consumer of the execute→memory pipeline register outputs. It turns the M-stage control/data (ALU address, store data, funct3, ResultSrc, MemWrite) into a req/ack data-bus transaction and returns aligned, extended load data for the writeback register. While a transaction is outstanding it raises `StallM`, which the pipeline uses to hold the E/M register and all earlier stages.

## Interface
Parameters:
- `ADDR_W`, 32: bus address width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ALUResultM` in 32: effective address.
- `WriteDataM` in 32: store data, right-justified.
- `ResultSrcM` in 2: `01` marks a load; other codes are not memory reads.
- `MemWriteM` in 1: store.
- `funct3M` in 3: size/sign. `000` B, `001` H, `010` W, `100` BU, `101` HU.
- `bus_req` out 1: transaction request, registered.
- `bus_we` out 1: 1 for a store.
- `bus_addr` out ADDR_W: word-aligned address (`[1:0]`=0).
- `bus_wdata` out 32: store data replicated across byte lanes.
- `bus_be` out 4: byte enables.
- `bus_rdata` in 32: read word, valid with `bus_ack`.
- `bus_ack` in 1: completion, one-cycle pulse.
- `ReadDataM` out 32: aligned/extended load result.
- `StallM` out 1: combinational; hold the pipeline.

## Operation
- Access present when `MemWriteM | (ResultSrcM==2'b01)`. `MemWriteM` wins if both are set.
- States are IDLE, WAIT and DONE.
  - IDLE + access: latch address, we, wdata, be and funct3/offset; go to WAIT. Without an access, stay in IDLE.
  - WAIT: `bus_req`=1. Address, we, wdata and be are held stable from the latched copies. On `bus_ack`, register `bus_rdata` (loads) and go to DONE. Otherwise stay in WAIT.
  - DONE: single cycle, then always IDLE.
- `StallM` is 1 in IDLE with an access present and throughout WAIT. It is 0 in DONE, so the pipeline advances at the DONE edge.
- Byte enables: B gives `1<<addr[1:0]`; H gives `0011` or `1100` by `addr[1]`; W gives `1111`.
- Store data replication: B gives `{4{wd[7:0]}}`; H gives `{2{wd[15:0]}}`; W passes through.
- Load extraction selects a byte or half by the latched offset.
  - B/H sign-extend.
  - BU/HU zero-extend.
  - W passes through.
- `ReadDataM` comes from the registered word. It is valid in DONE and holds its value until the next ack.
- `bus_ack` outside WAIT is ignored.
- Reset values: `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_be`, `ReadDataM` are 0; state is IDLE. `StallM` follows its combinational rule.
- Reset mid-WAIT drops `bus_req` immediately and abandons the transaction. The bus must tolerate this, and a late ack is ignored.

## Timing
- Access in M at cycle 0 (IDLE): `bus_req` rises at cycle 1.
- With ack at cycle 1, the unit is in DONE at cycle 2 and the next instruction enters M at cycle 3.
- A memory instruction occupies M for (3 + wait cycles) cycles. The stall is asserted for (2 + wait cycles) cycles.
- Back-to-back accesses: DONE→IDLE, then the new access is accepted in its first M cycle. No gap cycle on the bus beyond IDLE.
- Non-memory instructions: zero stall, bus idle.

## Configuration
- `PL_LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned H (`addr[0]`) or W (`addr[1:0]!=0`) issues no bus request.
  - Output `MisalignM` (1 bit) is asserted combinationally, and `StallM` stays 0.
- Undefined:
  - No `MisalignM` port.
  - Misaligned accesses go to the containing word. Halves use `addr[1]`; words ignore `addr[1:0]`.

## Structure
- Package `pl_mem_pkg` holds:
  - funct3 size constants;
  - the ResultSrc encoding (`RES_MEM`=`2'b01`);
  - the state enum.
- Sub-module `pl_load_align`: combinational extract/extend taking (word, offset, funct3) and producing 32-bit data. It is instantiated once.

## Test plan
- SW addr `0x100`, data `0xDEADBEEF`, ack in first WAIT cycle → `bus_addr` 0x100, `bus_be` 1111, `bus_we` 1, `StallM` high 2 cycles.
- SB addr `0x103`, data `0x000000AB` → `bus_be` 1000, `bus_wdata` `0xABABABAB`.
- LB addr `0x102`, rdata `0x12F05634` → `ReadDataM` `0xFFFFFFF0`. Same with LBU → `0x000000F0`.
- LH addr `0x102`, ack after 3 WAIT cycles, rdata `0x80010000` → `ReadDataM` `0xFFFF8001`, `StallM` high 5 cycles.
- `rst_n` low during WAIT → `bus_req` 0 immediately, state IDLE, `ReadDataM` 0. Ack one cycle after release is ignored.
- LW addr `0x102`:
  - with the macro → no `bus_req`, `MisalignM`=1, `StallM`=0;
  - without it → `bus_addr` 0x100, `bus_be` 1111.
